mem_port_arbiter: RTL and testbench

Shares one synchronous single-port 16-bit memory between the CPU's instruction-fetch requester and its data (load/store) requester. It sits between the `cpu` fetch/execute stages and the memory macro. It grants at most one access per cycle, with data priority and an optional anti-starvation rule. It also routes each one-cycle-latency read response back to the requester that issued it.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/arb_starve_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 80 ++++++++
 tb/tb_mem_port_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: memory response owner and bus widths.
package cpu_pkg;

   localparam int CPU_AWIDTH = 16;
   localparam int CPU_DWIDTH = 16;

   typedef enum logic [1:0] {
      OWNER_NONE  = 2'd0,
      OWNER_FETCH = 2'd1,
      OWNER_DATA  = 2'd2
   } mem_owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants won while fetch waits.
// Raises force_fetch once the count reaches LIMIT.
module arb_starve_counter #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic i_gnt,
   input  logic d_gnt,
   output logic force_fetch
);

   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] MAX = CW'(LIMIT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!i_req || i_gnt) begin
         cnt <= '0;
      end else if (d_gnt && (cnt != MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign force_fetch = i_req && (cnt == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port memory with response routing.
// Define MEM_ARB_FAIRNESS_EN to bound fetch starvation.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int AWIDTH       = CPU_AWIDTH,
   parameter int DWIDTH       = CPU_DWIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [AWIDTH-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DWIDTH-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AWIDTH-1:0] d_addr,
   input  logic [DWIDTH-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DWIDTH-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   mem_owner_t rsp_owner;
   mem_owner_t rsp_next;
   logic       force_fetch;

`ifdef MEM_ARB_FAIRNESS_EN
   arb_starve_counter #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_gnt      (i_gnt),
      .d_gnt      (d_gnt),
      .force_fetch(force_fetch)
   );
`else
   assign force_fetch = 1'b0;
`endif

   assign d_gnt = !rst && d_req && !force_fetch;
   assign i_gnt = !rst && i_req && (!d_req || force_fetch);

   assign mem_en    = i_gnt | d_gnt;
   assign mem_we    = d_gnt & d_we;
   assign mem_addr  = d_gnt ? d_addr : i_addr;
   assign mem_wdata = d_wdata;

   always_comb begin
      rsp_next = OWNER_NONE;
      unique case (1'b1)
         i_gnt:          rsp_next = OWNER_FETCH;
         d_gnt && !d_we: rsp_next = OWNER_DATA;
         default:        rsp_next = OWNER_NONE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_owner <= OWNER_NONE;
      end else begin
         rsp_owner <= rsp_next;
      end
   end

   assign i_rvalid = (rsp_owner == OWNER_FETCH);
   assign d_rvalid = (rsp_owner == OWNER_DATA);
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory.
module tb_mem_port_arbiter;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
   logic [15:0] i_rdata, d_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   typedef struct {
      mem_owner_t  owner;
      logic [15:0] data;
   } rsp_t;

   rsp_t        sb[$];
   logic [15:0] mem     [0:4095];
   logic [15:0] ref_mem [0:4095];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_gnt    (i_gnt),
      .i_rvalid (i_rvalid),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr[11:0]];
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input string tag,
                        input logic ir, input logic [15:0] ia,
                        input logic dr, input logic dwe,
                        input logic [15:0] da, input logic [15:0] dwd,
                        input logic ei, input logic ed);
      rsp_t e;
      rsp_t r;
      i_req = ir; i_addr = ia;
      d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
      #1;
      check({tag, " i_gnt"}, i_gnt, ei);
      check({tag, " d_gnt"}, d_gnt, ed);
      check({tag, " mem_en"}, mem_en, ei | ed);
      check({tag, " mem_we"}, mem_we, ed & dwe);
      if (ed) begin
         check({tag, " mem_addr"}, mem_addr, da);
         if (dwe) check({tag, " mem_wdata"}, mem_wdata, dwd);
      end else if (ei) begin
         check({tag, " mem_addr"}, mem_addr, ia);
      end
      e.owner = OWNER_NONE;
      e.data  = '0;
      if (ei) begin
         e.owner = OWNER_FETCH;
         e.data  = ref_mem[ia[11:0]];
      end else if (ed && !dwe) begin
         e.owner = OWNER_DATA;
         e.data  = ref_mem[da[11:0]];
      end
      if (ed && dwe) ref_mem[da[11:0]] = dwd;
      sb.push_back(e);
      @(posedge clk); #1;
      r = sb.pop_front();
      check({tag, " i_rvalid"}, i_rvalid, r.owner == OWNER_FETCH);
      check({tag, " d_rvalid"}, d_rvalid, r.owner == OWNER_DATA);
      if (r.owner == OWNER_FETCH) check({tag, " i_rdata"}, i_rdata, r.data);
      if (r.owner == OWNER_DATA)  check({tag, " d_rdata"}, d_rdata, r.data);
   endtask

   initial begin
      logic ei;
      for (int i = 0; i < 4096; i++) begin
         mem[i]     = 16'(i * 7 + 16'h1111);
         ref_mem[i] = 16'(i * 7 + 16'h1111);
      end
      mem[16'h0010]     = 16'hABCD;
      ref_mem[16'h0010] = 16'hABCD;
      mem[16'h0200]     = 16'h5A5A;
      ref_mem[16'h0200] = 16'h5A5A;

      rst = 1'b1;
      i_req = 1'b1; i_addr = 16'h0010;
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst i_gnt", i_gnt, 1'b0);
      check("rst d_gnt", d_gnt, 1'b0);
      check("rst mem_en", mem_en, 1'b0);
      check("rst mem_we", mem_we, 1'b0);
      check("rst i_rvalid", i_rvalid, 1'b0);
      check("rst d_rvalid", d_rvalid, 1'b0);
      rst = 1'b0;

      drive("idle", 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
      drive("fetch", 1, 16'h0010, 0, 0, 16'h0, 16'h0, 1, 0);
      drive("cont_rd", 1, 16'h0010, 1, 0, 16'h0200, 16'h0, 0, 1);
      drive("cont_if", 1, 16'h0010, 0, 0, 16'h0200, 16'h0, 1, 0);
      drive("store", 0, 16'h0, 1, 1, 16'h0300, 16'h1234, 0, 1);
      drive("load_st", 0, 16'h0, 1, 0, 16'h0300, 16'h0, 0, 1);
      drive("b2b_if", 1, 16'h0044, 0, 0, 16'h0, 16'h0, 1, 0);
      drive("b2b_d", 0, 16'h0, 1, 0, 16'h0045, 16'h0, 0, 1);
      drive("idle2", 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);

      for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_FAIRNESS_EN
         ei = (k % 5 == 4);
`else
         ei = 1'b0;
`endif
         drive($sformatf("starve%0d", k), 1, 16'h0010, 1, 0,
               16'h0200, 16'h0, ei, !ei);
      end
      drive("idle3", 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);

      i_req = 1'b1; i_addr = 16'h0010; d_req = 1'b0; d_we = 1'b0;
      #1;
      check("mid i_gnt", i_gnt, 1'b1);
      @(posedge clk); #1;
      i_req = 1'b0;
      rst = 1'b1;
      #1;
      check("mid async i_rvalid", i_rvalid, 1'b0);
      check("mid async d_rvalid", d_rvalid, 1'b0);
      @(posedge clk); #1;
      check("mid held i_rvalid", i_rvalid, 1'b0);
      rst = 1'b0;
      drive("post_rst", 1, 16'h0010, 0, 0, 16'h0, 16'h0, 1, 0);
      drive("post_rd", 0, 16'h0, 1, 0, 16'h0200, 16'h0, 0, 1);
      drive("idle4", 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);

      check("sb empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
